// File: rtl/line_mem_ctrl.sv
// rtl/line_mem_ctrl.sv - line-granular backing memory: 256-bit line requests serialised into eight 32-bit beats
// Optional request statistics counters are built when MEM_STAT_EN is defined.
module line_mem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         we,
    input  logic [31:0]  addr,
    input  logic [255:0] wdata,
    output logic [255:0] rdata,
    output logic         ack,
    output logic         busy,
    output logic [15:0]  stat_rd_cnt,
    output logic [15:0]  stat_wr_cnt
);

    localparam int         LINE_W = ADDR_WIDTH - 3;
    localparam logic [3:0] LAT    = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_ACK
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          lat_q;
    logic [3:0]          beat_q;
    logic [3:0]          cap_idx;
    logic                we_q;
    logic [LINE_W-1:0]   line_q;
    logic [255:0]        wdata_q;
    logic [255:0]        rdata_q;
    logic                xfer_done;

    logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0]           ram_q;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;

    // Line offset bits and address bits above the RAM are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{addr[31:ADDR_WIDTH+2], addr[4:0], cap_idx[3]};

    assign ram_addr  = {line_q, beat_q[2:0]};
    assign ram_we    = (state_q == S_XFER) && we_q && !rst;
    assign xfer_done = we_q ? (beat_q == 4'd7) : (beat_q == 4'd8);
    // Read data lags the issued address by one cycle, so beat n captures word n-1.
    assign cap_idx   = beat_q - 4'd1;

    assign rdata = rdata_q;
    assign ack   = (state_q == S_ACK);
    assign busy  = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= wdata_q[{beat_q[2:0], 5'b00000} +: 32];
        end
        ram_q <= mem[ram_addr];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = (LATENCY > 0) ? S_WAIT : S_XFER;
                end
            end
            S_WAIT: begin
                if (lat_q <= 4'd1) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (xfer_done) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= 4'd0;
            beat_q  <= 4'd0;
            we_q    <= 1'b0;
            line_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        wdata_q <= wdata;
                        line_q  <= addr[ADDR_WIDTH+1:5];
                        lat_q   <= LAT;
                        beat_q  <= 4'd0;
                    end
                end
                S_WAIT: begin
                    lat_q <= lat_q - 4'd1;
                end
                S_XFER: begin
                    beat_q <= beat_q + 4'd1;
                    if (!we_q && (beat_q != 4'd0)) begin
                        rdata_q[{cap_idx[2:0], 5'b00000} +: 32] <= ram_q;
                    end
                end
                S_ACK: begin
                    beat_q <= 4'd0;
                end
                default: begin
                    beat_q <= 4'd0;
                end
            endcase
        end
    end

`ifdef MEM_STAT_EN
    logic [15:0] stat_rd_q;
    logic [15:0] stat_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_q <= 16'd0;
            stat_wr_q <= 16'd0;
        end else if (state_q == S_ACK) begin
            if (!we_q && (stat_rd_q != 16'hFFFF)) begin
                stat_rd_q <= stat_rd_q + 16'd1;
            end
            if (we_q && (stat_wr_q != 16'hFFFF)) begin
                stat_wr_q <= stat_wr_q + 16'd1;
            end
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`else
    assign stat_rd_cnt = 16'd0;
    assign stat_wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb/tb_line_mem_ctrl.sv - self-checking bench for line_mem_ctrl (LATENCY=4 and LATENCY=0 instances)
module tb_line_mem_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req4, req0;
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata4, rdata0;
    logic         ack4, ack0, busy4, busy0;
    logic [15:0]  srd4, swr4, srd0, swr0;

    always #5 clk = ~clk;

    line_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .ack(ack4), .busy(busy4), .stat_rd_cnt(srd4), .stat_wr_cnt(swr4)
    );

    line_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ack(ack0), .busy(busy0), .stat_rd_cnt(srd0), .stat_wr_cnt(swr0)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: index 1 = LATENCY 4 instance, index 0 = LATENCY 0 instance.
    logic [255:0] mline [0:1][0:127];
    bit           mvalid [0:1][0:127];
    logic [255:0] last_rd [0:1];
    bit           last_known [0:1];
    int           rd_done [0:1];
    int           wr_done [0:1];

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % 128);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] stat_exp(input int c);
`ifdef MEM_STAT_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return (c >= 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_rd[s] = '0;
            last_known[s] = 1'b1;
            rd_done[s] = 0;
            wr_done[s] = 0;
        end
    endtask

    task automatic do_txn(input int sel, input bit w, input logic [31:0] a, input logic [255:0] d);
        int n;
        int lat;
        int li;
        bit got;
        bit busy_ok;
        logic [255:0] rd;
        lat = (sel == 1) ? 4 : 0;
        li  = line_of(a);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        if (sel == 1) req4 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        req4 = 1'b0; req0 = 1'b0;
        n = 0; got = 0; busy_ok = 1;
        while (!got && n < 60) begin
            if ((sel == 1) ? ack4 : ack0) got = 1;
            else begin
                if (!((sel == 1) ? busy4 : busy0)) busy_ok = 0;
                @(posedge clk); #1;
                n++;
            end
        end
        checks++;
        if (!got || n != lat + (w ? 8 : 9)) begin
            failures++;
            $display("FAIL ack_latency sel=%0d we=%0d got_edges=%0d seen=%0d expected_edges=%0d", sel, w, n, got, lat + (w ? 8 : 9));
        end
        checks++;
        if (!busy_ok) begin
            failures++;
            $display("FAIL busy_during sel=%0d we=%0d busy dropped before ack, expected 1", sel, w);
        end
        rd = (sel == 1) ? rdata4 : rdata0;
        if (w) begin
            if (last_known[sel]) begin
                checks++;
                if (rd !== last_rd[sel]) begin
                    failures++;
                    $display("FAIL rdata_hold sel=%0d got=%h exp=%h", sel, rd, last_rd[sel]);
                end
            end
            mline[sel][li] = d;
            mvalid[sel][li] = 1'b1;
            wr_done[sel]++;
        end else begin
            if (mvalid[sel][li]) begin
                checks++;
                if (rd !== mline[sel][li]) begin
                    failures++;
                    $display("FAIL rdata_line sel=%0d addr=%h got=%h exp=%h", sel, a, rd, mline[sel][li]);
                end
                last_rd[sel] = mline[sel][li];
                last_known[sel] = 1'b1;
            end else begin
                last_known[sel] = 1'b0;
            end
            rd_done[sel]++;
        end
        @(posedge clk); #1;
        checks++;
        if (((sel == 1) ? {busy4, ack4} : {busy0, ack0}) !== 2'b00) begin
            failures++;
            $display("FAIL busy_after_ack sel=%0d got busy/ack=%b%b exp=00", sel,
                     (sel == 1) ? busy4 : busy0, (sel == 1) ? ack4 : ack0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req4 = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({ack4, busy4, rdata4} !== '0) begin
                failures++;
                $display("FAIL reset_idle4 cycle=%0d ack=%b busy=%b rdata=%h exp all 0", c, ack4, busy4, rdata4);
            end
            checks++;
            if ({ack0, busy0, rdata0} !== '0) begin
                failures++;
                $display("FAIL reset_idle0 cycle=%0d ack=%b busy=%b rdata=%h exp all 0", c, ack0, busy0, rdata0);
            end
        end
    endtask

    task automatic test_basic();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'h11111111 * (i + 1);
        do_txn(1, 1'b1, 32'h40, d);
        do_txn(1, 1'b0, 32'h40, '0);
    endtask

    task automatic test_lat0();
        do_txn(0, 1'b0, 32'h3E0, '0);
        do_txn(0, 1'b1, 32'h3E0, rand_line());
        do_txn(0, 1'b0, 32'h3E0, '0);
    endtask

    task automatic test_wrap();
        do_txn(1, 1'b1, 32'h1020, rand_line());
        do_txn(1, 1'b0, 32'h0020, '0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int li;
        bit w;
        for (int k = 0; k < 24; k++) begin
            int sel;
            sel = k % 2;
            li  = $urandom_range(0, 7);
            a   = ($urandom << 12) | (32'(li) << 5) | 32'($urandom_range(0, 31));
            w   = !mvalid[sel][li] || ($urandom_range(0, 1) == 1);
            do_txn(sel, w, a, rand_line());
        end
    endtask

    task automatic test_abort();
        logic [255:0] oldv, newv;
        oldv = rand_line();
        newv = rand_line();
        do_txn(1, 1'b1, 32'h80, oldv);
        do_txn(1, 1'b0, 32'h80, '0);
        @(negedge clk);
        we = 1'b1; addr = 32'h80; wdata = newv; req4 = 1'b1;
        @(posedge clk); #1;
        req4 = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            checks++;
            if (ack4 !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_ack edge=%0d got=%b exp=0", n, ack4);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy4, ack4, rdata4} !== '0) begin
            failures++;
            $display("FAIL abort_reset busy=%b ack=%b rdata=%h exp all 0", busy4, ack4, rdata4);
        end
        // Reset together with a request: the request must be dropped.
        @(negedge clk);
        req4 = 1'b1; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req4 = 1'b0;
        model_reset();
        mline[1][4] = {oldv[255:96], newv[95:0]};
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy4, ack4} !== 2'b00) begin
                failures++;
                $display("FAIL reset_wins cycle=%0d busy=%b ack=%b exp 00", n, busy4, ack4);
            end
        end
        do_txn(1, 1'b0, 32'h80, '0);
    endtask

    task automatic test_stats();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) do_txn(1, 1'b0, 32'h40, '0);
        for (int k = 0; k < 2; k++) do_txn(1, 1'b1, 32'h40 + 32'(k) * 32'h20, rand_line());
        do_txn(0, 1'b0, 32'h3E0, '0);
        checks++;
        if (srd4 !== stat_exp(rd_done[1])) begin
            failures++;
            $display("FAIL stat_rd4 got=%0d exp=%0d", srd4, stat_exp(rd_done[1]));
        end
        checks++;
        if (swr4 !== stat_exp(wr_done[1])) begin
            failures++;
            $display("FAIL stat_wr4 got=%0d exp=%0d", swr4, stat_exp(wr_done[1]));
        end
        checks++;
        if ({srd0, swr0} !== {stat_exp(rd_done[0]), stat_exp(wr_done[0])}) begin
            failures++;
            $display("FAIL stat0 got=%0d/%0d exp=%0d/%0d", srd0, swr0, stat_exp(rd_done[0]), stat_exp(wr_done[0]));
        end
`ifdef MEM_STAT_EN
        @(negedge clk);
        dut4.stat_rd_q = 16'hFFFF;
        rd_done[1] = 65535;
        do_txn(1, 1'b0, 32'h40, '0);
        checks++;
        if (srd4 !== stat_exp(rd_done[1])) begin
            failures++;
            $display("FAIL stat_saturate got=%h exp=%h", srd4, stat_exp(rd_done[1]));
        end
`endif
    endtask

    initial begin
        rst = 1'b1; req4 = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < 128; l++) mvalid[s][l] = 1'b0;
        test_reset();
        test_basic();
        test_lat0();
        test_wrap();
        test_random();
        test_abort();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
